// File: rtl/colour_fp_pkg.sv
// Shared constants and per-stage records for the fixed-to-float colour converter.
package colour_fp_pkg;

    localparam int          FP_BIAS = 127;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam int          MAX_W   = 16;

    typedef enum logic {
        MODE_UNIT = 1'b0,
        MODE_RAW  = 1'b1
    } mode_e;

    // vn is left-aligned in MAX_W bits so the record is width-independent
    typedef struct packed {
        logic             is_zero;
        logic             is_max;
        mode_e            mode;
        logic [4:0]       lz;
        logic [MAX_W-1:0] vn;
    } s1_t;

    typedef struct packed {
        logic        is_zero;
        logic        is_max;
        mode_e       mode;
        logic [7:0]  exp;
        logic [22:0] man;
        logic        guard;
        logic        sticky;
    } s2_t;

endpackage

// File: rtl/colour_fp_lane.sv
// One colour channel's three-stage datapath: normalise, mantissa expansion, round/pack.
module colour_fp_lane
    import colour_fp_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter bit MODE_RAW_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              adv_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              mode_i,
    output logic [31:0]       data_o
);

    // enough copies of vn to cover hidden bit + 23 mantissa bits + guard
    localparam int                K     = 40 / DATA_W + 2;
    localparam int                REP_W = K * DATA_W;
    localparam logic [DATA_W-1:0] V_MAX = '1;

    s1_t               s1_d, s1_q;
    s2_t               s2_d, s2_q;
    logic [4:0]        lz;
    logic [MAX_W-1:0]  v_ext;
    logic [DATA_W-1:0] vn;
    logic [REP_W-1:0]  rep;
    logic              round_up;
    logic [23:0]       man_sum;
    logic [7:0]        exp_r;
    logic [31:0]       pack_d;

    always_comb begin
        lz = 5'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (data_i[i]) lz = 5'(DATA_W - 1 - i);
        end
        v_ext        = MAX_W'(data_i);
        s1_d         = '0;
        s1_d.is_zero = (data_i == '0);
        s1_d.is_max  = (data_i == V_MAX);
        s1_d.mode    = (MODE_RAW_EN && mode_i) ? MODE_RAW : MODE_UNIT;
        s1_d.lz      = lz;
        s1_d.vn      = v_ext << (5'(MAX_W - DATA_W) + lz);
    end

    // v/(2^N-1) read from its leading one is vn repeated forever, so the
    // tail below the guard bit always holds a one: sticky is set for v != 0
    always_comb begin
        vn           = s1_q.vn[MAX_W-1 -: DATA_W];
        rep          = {K{vn}};
        s2_d         = '0;
        s2_d.is_zero = s1_q.is_zero;
        s2_d.is_max  = s1_q.is_max;
        s2_d.mode    = s1_q.mode;
        if (s1_q.mode == MODE_RAW) begin
            s2_d.exp = 8'(FP_BIAS + DATA_W - 1) - {3'b0, s1_q.lz};
            s2_d.man = {s1_q.vn[MAX_W-2:0], 8'b0};
        end else begin
            s2_d.exp    = 8'(FP_BIAS - 1) - {3'b0, s1_q.lz};
            s2_d.man    = rep[REP_W-2 -: 23];
            s2_d.guard  = rep[REP_W-25];
            s2_d.sticky = ~s1_q.is_zero;
        end
    end

    always_comb begin
        round_up = s2_q.guard & (s2_q.sticky | s2_q.man[0]);
        man_sum  = {1'b0, s2_q.man} + {23'b0, round_up};
        exp_r    = s2_q.exp + {7'b0, man_sum[23]};
        if (s2_q.is_zero) begin
            pack_d = FP_ZERO;
        end else if (s2_q.is_max && s2_q.mode == MODE_UNIT) begin
            pack_d = FP_ONE;
        end else begin
            pack_d = {1'b0, exp_r, man_sum[22:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= '0;
            s2_q   <= '0;
            data_o <= '0;
        end else if (adv_i) begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            data_o <= pack_d;
        end
    end

endmodule

// File: rtl/colour_fixed_to_float_pipe.sv
// Pipelined unsigned colour channel to IEEE-754 single converter with valid/ready
// on both sides; owns the shared valid pipeline and the lanes.
module colour_fixed_to_float_pipe #(
    parameter int DATA_W      = 8,
    parameter int CH          = 3,
    parameter bit MODE_RAW_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CH*DATA_W-1:0] data_i,
    input  logic                 mode_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CH*32-1:0]     data_o,
    output logic                 busy_o
);

    logic       adv;
    logic [2:0] vld_q;

    // whole pipe moves as one; bubbles are kept, not squeezed out
    assign adv         = out_ready_i | ~vld_q[2];
    assign in_ready_o  = adv;
    assign out_valid_o = vld_q[2];
    assign busy_o      = |vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[1:0], in_valid_i};
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        colour_fp_lane #(
            .DATA_W      (DATA_W),
            .MODE_RAW_EN (MODE_RAW_EN)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .adv_i  (adv),
            .data_i (data_i[c*DATA_W +: DATA_W]),
            .mode_i (mode_i),
            .data_o (data_o[c*32 +: 32])
        );
    end

endmodule

// File: tb/tb_colour_fixed_to_float_pipe.sv
// Randomised bench: scoreboard against a real-arithmetic model with RNE to single.
module tb_colour_fixed_to_float_pipe;

    localparam int W  = 8;
    localparam int CH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [CH*W-1:0]   din       = '0;
    logic              mode      = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CH*32-1:0]  dout;
    logic              busy;

    logic        aval   = 1'b0;
    logic        aux_en = 1'b0;
    logic [15:0] a16_d  = '0;
    logic [9:0]  a10_d  = '0;
    logic [4:0]  a5_d   = '0;
    logic [0:0]  a1_d   = '0;
    logic        a16_m = 1'b0, a10_m = 1'b0, a5_m = 1'b0, a1_m = 1'b0;
    logic        a16_ir, a10_ir, a5_ir, a1_ir;
    logic        a16_ov, a10_ov, a5_ov, a1_ov;
    logic        a16_bz, a10_bz, a5_bz, a1_bz;
    logic [31:0] a16_do, a10_do, a5_do, a1_do;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CH*32-1:0] exp_q[$];
    logic [31:0]      q16[$], q10[$], q5[$], q1[$];
    logic             stall_prev = 1'b0;
    logic [CH*32-1:0] stall_data;

    colour_fixed_to_float_pipe #(.DATA_W(W), .CH(CH), .MODE_RAW_EN(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_i(din), .mode_i(mode), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_o(dout), .busy_o(busy));

    colour_fixed_to_float_pipe #(.DATA_W(16), .CH(1), .MODE_RAW_EN(1'b1)) u_a16 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(aval), .in_ready_o(a16_ir),
        .data_i(a16_d), .mode_i(a16_m), .out_valid_o(a16_ov), .out_ready_i(1'b1),
        .data_o(a16_do), .busy_o(a16_bz));

    colour_fixed_to_float_pipe #(.DATA_W(10), .CH(1), .MODE_RAW_EN(1'b1)) u_a10 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(aval), .in_ready_o(a10_ir),
        .data_i(a10_d), .mode_i(a10_m), .out_valid_o(a10_ov), .out_ready_i(1'b1),
        .data_o(a10_do), .busy_o(a10_bz));

    colour_fixed_to_float_pipe #(.DATA_W(5), .CH(1), .MODE_RAW_EN(1'b0)) u_a5 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(aval), .in_ready_o(a5_ir),
        .data_i(a5_d), .mode_i(a5_m), .out_valid_o(a5_ov), .out_ready_i(1'b1),
        .data_o(a5_do), .busy_o(a5_bz));

    colour_fixed_to_float_pipe #(.DATA_W(1), .CH(1), .MODE_RAW_EN(1'b1)) u_a1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(aval), .in_ready_o(a1_ir),
        .data_i(a1_d), .mode_i(a1_m), .out_valid_o(a1_ov), .out_ready_i(1'b1),
        .data_o(a1_do), .busy_o(a1_bz));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // round-to-nearest-even of a non-negative real to IEEE single
    function automatic logic [31:0] to_f32(input real x);
        real    m, sc, fr;
        int     e;
        longint mi;
        if (x == 0.0) return 32'h0;
        m = x;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        sc = (m - 1.0) * 8388608.0;
        mi = longint'($floor(sc));
        fr = sc - real'(mi);
        if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
        if (mi == 64'd8388608) begin mi = 0; e++; end
        return {1'b0, 8'(e + 127), 23'(mi)};
    endfunction

    function automatic logic [31:0] exp_f(input int unsigned v, input int w, input bit raw);
        if (raw) return to_f32(real'(v));
        return to_f32(real'(v) / real'((1 << w) - 1));
    endfunction

    function automatic logic [CH*32-1:0] model(input logic [CH*W-1:0] d, input logic m);
        logic [CH*32-1:0] r;
        logic [W-1:0]     v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            v = d[c*W +: W];
            r[c*32 +: 32] = exp_f(v, W, m);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            q16.delete(); q10.delete(); q5.delete(); q1.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", dout, stall_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
                else chk("stream", dout, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(model(din, mode));
            stall_prev = out_valid && !out_ready;
            stall_data = dout;

            if (aux_en) begin
                if (a16_ov) begin
                    if (q16.size() == 0) chk("a16_extra", 1'b1, 1'b0);
                    else chk("a16", a16_do, q16.pop_front());
                end
                if (a10_ov) begin
                    if (q10.size() == 0) chk("a10_extra", 1'b1, 1'b0);
                    else chk("a10", a10_do, q10.pop_front());
                end
                if (a5_ov) begin
                    if (q5.size() == 0) chk("a5_extra", 1'b1, 1'b0);
                    else chk("a5", a5_do, q5.pop_front());
                end
                if (a1_ov) begin
                    if (q1.size() == 0) chk("a1_extra", 1'b1, 1'b0);
                    else chk("a1", a1_do, q1.pop_front());
                end
                if (aval && a16_ir) q16.push_back(exp_f(a16_d, 16, a16_m));
                if (aval && a10_ir) q10.push_back(exp_f(a10_d, 10, a10_m));
                if (aval && a5_ir)  q5.push_back(exp_f(a5_d, 5, 1'b0));
                if (aval && a1_ir)  q1.push_back(exp_f(a1_d, 1, a1_m));
            end
        end
    end

    task automatic send(input logic [CH*W-1:0] d, input logic m, input bit bp);
        bit acc;
        int tries;
        din      = d;
        mode     = m;
        in_valid = 1'b1;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 100) begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            @(posedge clk); #1;
            tries++;
        end
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        int cyc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [CH*32-1:0] first_exp;
        logic [CH*W-1:0]  first_d;
        logic [31:0]      iv;
        int               cyc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", dout, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        din = {8'hFF, 8'h80, 8'h01}; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("latency_early", out_valid, 1'b0);
        chk("busy_inflight", busy, 1'b1);
        @(posedge clk); #1;
        chk("latency3_valid", out_valid, 1'b1);
        chk("unit_directed", dout, {32'h3F80_0000, 32'h3F00_8081, 32'h3B80_8081});

        din = {8'h00, 8'h01, 8'hFF}; mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("raw_directed", dout, {32'h0000_0000, 32'h3F80_0000, 32'h437F_0000});
        drain();

        for (int v = 0; v < 256; v++) begin
            iv = v;
            send({8'($urandom), 8'($urandom), iv[7:0]}, 1'b0, 1'b0);
        end
        drain();

        for (int b = 0; b < 30; b++) begin
            send(24'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        drain();

        for (int b = 0; b < 3; b++) send(24'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", dout, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", out_valid, 1'b0);
        first_d   = 24'($urandom);
        first_exp = model(first_d, 1'b0);
        send(first_d, 1'b0, 1'b0);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("post_rst_first", dout, first_exp);
        drain();

        aux_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            iv    = i;
            aval  = 1'b1;
            a10_d = iv[9:0];
            a10_m = 1'b0;
            a5_d  = iv[4:0];
            a5_m  = iv[5];
            a1_d  = iv[0:0];
            a1_m  = iv[1];
            case (i)
                0:       begin a16_d = 16'hFFFF; a16_m = 1'b1; end
                1:       begin a16_d = 16'hFFFF; a16_m = 1'b0; end
                2:       begin a16_d = 16'h0000; a16_m = 1'b1; end
                default: begin a16_d = 16'($urandom); a16_m = 1'($urandom_range(0, 1)); end
            endcase
            @(posedge clk); #1;
        end
        aval = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("aux_left", q16.size() + q10.size() + q5.size() + q1.size(), 0);
        chk("aux_busy_idle", {a16_bz, a10_bz, a5_bz, a1_bz}, 4'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
